nvm_core_initiator: RTL and testbench

NVM_CORE_INITIATOR -- requirements
Module: nvm_core_initiator

---
 rtl/nvm_core_pkg.sv | 29 ++
 rtl/nvm_wb_master_port.sv | 83 ++++++++
 rtl/nvm_core_initiator.sv | 173 +++++++++++++++++
 tb/tb_nvm_core_initiator.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvm_core_pkg.sv
// Shared definitions for the NVM core initiator: address region codes,
// FSM state encoding, index counter width and the address builder.
package nvm_core_pkg;

    // Width of the per-picture word index (covers 0..1024 without wrap)
    localparam int CNT_W = 11;

    // Region codes placed at adr[15:12]
    localparam logic [3:0] REGION_SYN  = 4'h0;
    localparam logic [3:0] REGION_SPK  = 4'h1;
    localparam logic [3:0] REGION_DONE = 4'h2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DONE_WR,
        READ,
        DRAIN,
        FINISH
    } state_t;

    // base | region<<12 | idx<<2 ; idx stays below 1024 so bit 12 is never touched
    function automatic logic [31:0] region_addr(input logic [31:0]      base,
                                                input logic [3:0]       region,
                                                input logic [CNT_W-1:0] idx);
        return base | {16'h0000, region, 12'h000} | {19'h0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/nvm_wb_master_port.sv
// Single-transfer Wishbone master. A req pulse while idle launches one
// registered cycle; it is held until ack (or ack-wait timeout) and dropped
// on the following edge. done/rdata/timeout are valid in the cycle the
// transfer terminates.
// Optional feature: define NVM_INITIATOR_TIMEOUT_EN for the ack-wait limit.
module nvm_wb_master_port
    import nvm_core_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] dat,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    // An ack only counts while stb is high; stray acks are ignored
    assign done  = wbm_stb_o && wbm_ack_i;
    assign rdata = wbm_dat_i;

`ifdef NVM_INITIATOR_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [WAIT_W-1:0] wait_cnt;

    // Count cycles spent waiting for ack in the current transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (!wbm_stb_o || done || timeout)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Fires in the TIMEOUT-th cycle of stb, so stb is high exactly TIMEOUT cycles
    assign timeout = wbm_stb_o && !wbm_ack_i && (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    // Bus registers: launch on req when idle, hold until ack/timeout, then clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
        end else if (wbm_stb_o) begin
            if (done || timeout) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                wbm_adr_o <= '0;
                wbm_dat_o <= '0;
                wbm_sel_o <= '0;
            end
        end else if (req) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= we;
            wbm_adr_o <= adr;
            wbm_dat_o <= dat;
            wbm_sel_o <= 4'hF;
        end
    end

endmodule

// File: rtl/nvm_core_initiator.sv
// Picture sequencer for an NVM neuromorphic core: streams N_IN input words
// into the synapse region, writes the done register, then reads N_OUT
// spike words out one at a time through a single-word output buffer.
// Optional feature: define NVM_INITIATOR_TIMEOUT_EN to abort a picture
// when a slave fails to ack within TIMEOUT cycles (sticky error flag).
module nvm_core_initiator
    import nvm_core_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          N_IN      = 8,
    parameter int          N_OUT     = 4,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy,
    output logic        error
);

    localparam logic [CNT_W-1:0] IN_CNT   = CNT_W'(N_IN);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(N_OUT - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] idx;
    logic             req, req_we;
    logic [31:0]      req_adr, req_dat, rdata;
    logic             done, timeout;
    logic             in_accept, out_accept, last_word;

    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;
    assign last_word  = (idx == OUT_LAST);

    nvm_wb_master_port #(
        .TIMEOUT (TIMEOUT)
    ) u_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (req_we),
        .adr       (req_adr),
        .dat       (req_dat),
        .done      (done),
        .rdata     (rdata),
        .timeout   (timeout),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; a timeout in any bus phase abandons the picture
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (timeout) state_nx = FINISH;
                     else if (done && idx == IN_CNT) state_nx = DONE_WR;
            DONE_WR: if (timeout) state_nx = FINISH;
                     else if (done) state_nx = READ;
            READ:    if (timeout) state_nx = FINISH;
                     else if (done) state_nx = DRAIN;
            DRAIN:   if (out_accept) state_nx = last_word ? FINISH : READ;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Per-state outputs: stream ready and bus transfer request
    always_comb begin
        in_ready = 1'b0;
        req      = 1'b0;
        req_we   = 1'b0;
        req_adr  = '0;
        req_dat  = '0;
        case (state)
            LOAD: begin
                in_ready = !wbm_cyc_o && (idx < IN_CNT);
                req      = in_valid && in_ready;
                req_we   = 1'b1;
                req_adr  = region_addr(BASE_ADDR, REGION_SYN, idx);
                req_dat  = in_data;
            end
            DONE_WR: begin
                req      = !wbm_cyc_o;
                req_we   = 1'b1;
                req_adr  = region_addr(BASE_ADDR, REGION_DONE, '0);
                req_dat  = 32'h1;
            end
            READ: begin
                req      = !wbm_cyc_o;
                req_adr  = region_addr(BASE_ADDR, REGION_SPK, idx);
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE) && (state != FINISH);

    // Index counter and the single-word spike output buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (start) idx <= '0;
                LOAD:    if (in_accept) idx <= idx + 1'b1;
                DONE_WR: if (done) idx <= '0;
                READ: begin
                    if (done) begin
                        out_data  <= rdata;
                        out_valid <= 1'b1;
                        out_last  <= last_word;
                    end
                end
                DRAIN: begin
                    if (out_accept) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (!last_word) idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NVM_INITIATOR_TIMEOUT_EN
    // Sticky timeout flag, cleared when the next picture is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            error <= 1'b0;
        else if (state == IDLE && start)
            error <= 1'b0;
        else if (timeout)
            error <= 1'b1;
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_nvm_core_initiator.sv
// Self-checking bench for nvm_core_initiator: randomized pictures against a
// Wishbone slave model with configurable wait states and an expected
// transfer list built from the address map.
module tb_nvm_core_initiator;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int NI  = 3;
    localparam int NO  = 2;
    localparam int TMO = 8;
    localparam int BUDGET = 3000;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, wbm_ack_i = 1'b0;
    logic [31:0] in_data = '0, wbm_dat_i = '0;
    logic        in_ready, out_valid, out_last, busy, error;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] out_data, wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;

    int n_checks = 0;
    int n_fail   = 0;

    nvm_core_initiator #(
        .BASE_ADDR (BASE), .N_IN (NI), .N_OUT (NO), .TIMEOUT (TMO)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data), .out_last (out_last),
        .wbm_cyc_o (wbm_cyc_o), .wbm_stb_o (wbm_stb_o), .wbm_we_o (wbm_we_o),
        .wbm_adr_o (wbm_adr_o), .wbm_dat_o (wbm_dat_o), .wbm_sel_o (wbm_sel_o),
        .wbm_ack_i (wbm_ack_i), .wbm_dat_i (wbm_dat_i),
        .busy (busy), .error (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t       bus_log[$];
    int          ws_cfg = 0;
    int          ws_cnt = 0;
    bit          noack  = 1'b0;
    logic [31:0] in_words[NI];
    logic [31:0] spk[NO];

    // Slave: registered ack after ws_cfg wait states; logs every completed transfer
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_ack_i <= 1'b0;
            ws_cnt    <= 0;
        end else if (wbm_ack_i) begin
            wbm_ack_i <= 1'b0;
        end else if (wbm_stb_o && !noack) begin
            if (ws_cnt >= ws_cfg) begin
                wbm_ack_i <= 1'b1;
                ws_cnt    <= 0;
                bus_log.push_back({wbm_we_o, wbm_adr_o, wbm_dat_o});
                wbm_dat_i <= (wbm_adr_o[15:12] == 4'h1) ? spk[int'(wbm_adr_o[11:2]) % NO] : 32'hDEAD_BEEF;
            end else begin
                ws_cnt <= ws_cnt + 1;
            end
        end
    end

    // Expected n-th transfer of a picture, from the address map
    function automatic xfer_t exp_xfer(input int n);
        xfer_t e;
        if (n < NI)       e = '{1'b1, BASE + 32'(4 * n), in_words[n]};
        else if (n == NI) e = '{1'b1, BASE + 32'h2000, 32'h1};
        else              e = '{1'b0, BASE + 32'h1000 + 32'(4 * (n - NI - 1)), 32'h0};
        return e;
    endfunction

    logic [31:0] got_data[$];
    bit          got_last[$];
    int          stab_viol, pend_viol, sel_viol;
    bit          budget_hit;
    logic        err_after_start;

    task automatic randomize_data();
        foreach (in_words[i]) in_words[i] = $urandom;
        foreach (spk[i]) spk[i] = $urandom;
    endtask

    // Runs one picture with random stream handshakes; records observations only
    task automatic run_picture(input int ws, input int stall, input bit restart_mid);
        int k = 0, n = 0, hold = stall;
        logic pstb = 1'b0, pwe = 1'b0;
        logic [31:0] padr = '0, pdat = '0;
        ws_cfg = ws;
        bus_log.delete(); got_data.delete(); got_last.delete();
        stab_viol = 0; pend_viol = 0; sel_viol = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        err_after_start = error;
        while (busy && n < BUDGET) begin
            n++;
            start = restart_mid && (n == 4);
            if (pstb && wbm_stb_o && ({wbm_we_o, wbm_adr_o, wbm_dat_o} !== {pwe, padr, pdat})) stab_viol++;
            if (wbm_stb_o && (!wbm_cyc_o || wbm_sel_o !== 4'hF)) sel_viol++;
            if (out_valid && wbm_stb_o && !wbm_we_o) pend_viol++;
            pstb = wbm_stb_o; pwe = wbm_we_o; padr = wbm_adr_o; pdat = wbm_dat_o;
            if (k < NI && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; in_data = in_words[k];
            end else begin
                in_valid = 1'b0; in_data = $urandom;
            end
            if (in_valid && in_ready) k++;
            if (out_valid) begin
                if (hold > 0) begin out_ready = 1'b0; hold--; end
                else out_ready = ($urandom_range(0, 3) != 0);
                if (out_ready) begin got_data.push_back(out_data); got_last.push_back(out_last); end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        budget_hit = (n >= BUDGET);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 7'b0) begin
            n_fail++; $display("FAIL reset_bus_ctl: got %b, expected 0", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o});
        end
        n_checks++;
        if ({wbm_adr_o, wbm_dat_o, out_data} !== 96'b0) begin
            n_fail++; $display("FAIL reset_bus_data: adr=%h dat=%h out=%h, expected 0", wbm_adr_o, wbm_dat_o, out_data);
        end
        n_checks++;
        if ({in_ready, out_valid, out_last, busy, error} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b, expected 0", {in_ready, out_valid, out_last, busy, error});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        randomize_data();
        in_words[0] = 32'hA5A5_0001; in_words[1] = 32'hA5A5_0002; spk[0] = 32'h0000_00FF;
        run_picture(0, 0, 1'b0);
        n_checks++;
        if (budget_hit || bus_log.size() != NI + 1 + NO) begin
            n_fail++; $display("FAIL basic_count: got %0d transfers (timeout=%0b), expected %0d", bus_log.size(), budget_hit, NI + 1 + NO);
        end
        for (int i = 0; i < bus_log.size() && i < NI + 1 + NO; i++) begin
            xfer_t e = exp_xfer(i);
            n_checks++;
            if (bus_log[i].we !== e.we || bus_log[i].adr !== e.adr || (e.we && bus_log[i].dat !== e.dat)) begin
                n_fail++;
                $display("FAIL basic_xfer%0d: got we=%0b adr=%h dat=%h, expected we=%0b adr=%h dat=%h",
                         i, bus_log[i].we, bus_log[i].adr, bus_log[i].dat, e.we, e.adr, e.dat);
            end
        end
        for (int j = 0; j < NO; j++) begin
            n_checks++;
            if (j >= got_data.size() || got_data[j] !== spk[j] || got_last[j] !== (j == NO - 1)) begin
                n_fail++;
                $display("FAIL basic_out%0d: got %0d words (data=%h last=%0b), expected data=%h last=%0b", j, got_data.size(),
                         (j < got_data.size()) ? got_data[j] : 32'hx, (j < got_last.size()) ? got_last[j] : 1'bx, spk[j], j == NO - 1);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || error !== 1'b0 || sel_viol != 0) begin
            n_fail++; $display("FAIL basic_end: busy=%0b error=%0b sel_viol=%0d, expected 0/0/0", busy, error, sel_viol);
        end
    endtask

    task automatic test_wait_states();
        randomize_data();
        run_picture(3, 0, 1'b0);
        n_checks++;
        if (stab_viol != 0) begin
            n_fail++; $display("FAIL ws_stable: got %0d changes while waiting, expected 0", stab_viol);
        end
        n_checks++;
        if (bus_log.size() != NI + 1 + NO) begin
            n_fail++; $display("FAIL ws_count: got %0d transfers, expected %0d", bus_log.size(), NI + 1 + NO);
        end
        n_checks++;
        if (got_data.size() != NO || got_data[0] !== spk[0] || got_data[NO-1] !== spk[NO-1]) begin
            n_fail++; $display("FAIL ws_data: got %0d words, expected %0d words %h..%h", got_data.size(), NO, spk[0], spk[NO-1]);
        end
    endtask

    task automatic test_backpressure();
        randomize_data();
        run_picture(0, 10, 1'b0);
        n_checks++;
        if (pend_viol != 0) begin
            n_fail++; $display("FAIL bp_read_while_full: got %0d cycles, expected 0", pend_viol);
        end
        for (int j = 0; j < NO; j++) begin
            n_checks++;
            if (j >= got_data.size() || got_data[j] !== spk[j]) begin
                n_fail++; $display("FAIL bp_order%0d: got %0d words, expected word %h", j, got_data.size(), spk[j]);
            end
        end
        n_checks++;
        if (bus_log.size() != NI + 1 + NO || budget_hit) begin
            n_fail++; $display("FAIL bp_count: got %0d transfers, expected %0d", bus_log.size(), NI + 1 + NO);
        end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 3; p++) begin
            int bad = 0;
            randomize_data();
            run_picture($urandom_range(0, 2), $urandom_range(0, 4), 1'b1);
            for (int i = 0; i < bus_log.size(); i++) begin
                xfer_t e = exp_xfer(i);
                if (i >= NI + 1 + NO || bus_log[i].we !== e.we || bus_log[i].adr !== e.adr || (e.we && bus_log[i].dat !== e.dat)) bad++;
            end
            n_checks++;
            if (bad != 0 || bus_log.size() != NI + 1 + NO || budget_hit) begin
                n_fail++; $display("FAIL b2b_bus%0d: got %0d transfers, %0d wrong, expected %0d correct", p, bus_log.size(), bad, NI + 1 + NO);
            end
            n_checks++;
            if (got_data.size() != NO || got_data[0] !== spk[0] || got_data[NO-1] !== spk[NO-1] || got_last[NO-1] !== 1'b1 || got_last[0] !== 1'b0) begin
                n_fail++; $display("FAIL b2b_out%0d: got %0d words, expected %0d with last on final", p, got_data.size(), NO);
            end
            n_checks++;
            if (stab_viol != 0 || pend_viol != 0) begin
                n_fail++; $display("FAIL b2b_proto%0d: got stab=%0d pend=%0d, expected 0/0", p, stab_viol, pend_viol);
            end
        end
    endtask

    task automatic test_no_ack();
        int n = 0;
        noack = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!wbm_stb_o && n < 20) begin n++; @(negedge clk); end
        n_checks++;
        if (!wbm_stb_o) begin
            n_fail++; $display("FAIL noack_launch: stb=%0b, expected 1", wbm_stb_o);
        end
`ifdef NVM_INITIATOR_TIMEOUT_EN
        n = 0;
        while (wbm_stb_o && n < 100) begin n++; @(negedge clk); end
        in_valid = 1'b0;
        n_checks++;
        if (n != TMO) begin
            n_fail++; $display("FAIL tmo_stb_cycles: got %0d, expected %0d", n, TMO);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL tmo_flags: error=%0b busy=%0b cyc=%0b, expected 1/0/0", error, busy, wbm_cyc_o);
        end
        noack = 1'b0;
        randomize_data();
        run_picture(0, 0, 1'b0);
        n_checks++;
        if (err_after_start !== 1'b0 || error !== 1'b0) begin
            n_fail++; $display("FAIL tmo_clear: error after start=%0b at end=%0b, expected 0/0", err_after_start, error);
        end
        n_checks++;
        if (got_data.size() != NO || got_data[NO-1] !== spk[NO-1] || bus_log.size() != NI + 1 + NO) begin
            n_fail++; $display("FAIL tmo_recover: got %0d words %0d transfers, expected %0d/%0d", got_data.size(), bus_log.size(), NO, NI + 1 + NO);
        end
`else
        repeat (40) @(negedge clk);
        n_checks++;
        if (wbm_stb_o !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
            n_fail++; $display("FAIL noack_wait: stb=%0b busy=%0b error=%0b, expected 1/1/0", wbm_stb_o, busy, error);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        noack = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_read();
        int n = 0, k = 0;
        randomize_data();
        ws_cfg = 3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!(wbm_stb_o && !wbm_we_o) && n < 300) begin
            in_valid = (k < NI);
            in_data  = (k < NI) ? in_words[k] : 32'h0;
            if (in_valid && in_ready) k++;
            n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (!(wbm_stb_o && !wbm_we_o)) begin
            n_fail++; $display("FAIL rst_reach_read: stb=%0b we=%0b, expected read in flight", wbm_stb_o, wbm_we_o);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, in_ready, out_valid, out_last, busy, error} !== 12'b0 ||
            {wbm_adr_o, wbm_dat_o} !== 64'b0) begin
            n_fail++; $display("FAIL rst_mid_read: cyc=%0b stb=%0b busy=%0b adr=%h, expected all 0", wbm_cyc_o, wbm_stb_o, busy, wbm_adr_o);
        end
        @(negedge clk); rst_n = 1'b1;
        randomize_data();
        run_picture(0, 0, 1'b0);
        n_checks++;
        if (bus_log.size() != NI + 1 + NO || got_data.size() != NO || got_data[0] !== spk[0] || got_data[NO-1] !== spk[NO-1]) begin
            n_fail++; $display("FAIL rst_recover: got %0d transfers %0d words, expected %0d/%0d", bus_log.size(), got_data.size(), NI + 1 + NO, NO);
        end
        n_checks++;
        if (bus_log.size() > 0 && (bus_log[0].adr !== BASE || bus_log[0].dat !== in_words[0])) begin
            n_fail++; $display("FAIL rst_first_write: got adr=%h dat=%h, expected %h/%h", bus_log[0].adr, bus_log[0].dat, BASE, in_words[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_backpressure();
        test_back_to_back();
        test_no_ack();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
